// File: rtl/bsg_async_credit_returner_pkg.sv
// Shared types and sizing helpers for the async credit returner.
package bsg_async_credit_returner_pkg;

    typedef enum logic [2:0] {
        RST,
        GAP,
        IDLE,
        HI,
        LO
    } state_e;

    function automatic int pw(int max_tokens, int margin);
        return margin + $clog2(max_tokens + 1);
    endfunction

endpackage

// File: rtl/bsg_async_credit_returner_if.sv
// Local credit input plus token/status outputs of the credit returner.
interface bsg_async_credit_returner_if
    import bsg_async_credit_returner_pkg::*;
#(
    parameter int pw_p = pw(4, 0)
);

    logic            w_credit_i;
    logic            w_ready_o;
    logic [pw_p-1:0] w_tokens_pending_o;
    logic            w_error_o;
    logic            token_clk_o;
    logic            token_reset_o;

    modport master (
        input  w_credit_i,
        output w_ready_o,
        output w_tokens_pending_o,
        output w_error_o,
        output token_clk_o,
        output token_reset_o
    );

    modport slave (
        output w_credit_i,
        input  w_ready_o,
        input  w_tokens_pending_o,
        input  w_error_o,
        input  token_clk_o,
        input  token_reset_o
    );

endinterface

// File: rtl/bsg_credit_token_accum.sv
// Credit-to-token decimator feeding a saturating pending-token counter.
module bsg_credit_token_accum
    import bsg_async_credit_returner_pkg::*;
#(
    parameter int lg_p   = 0,
    parameter int pw_p   = 3,
    parameter int init_p = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            credit_i,
    input  logic            take_i,
    output logic [pw_p-1:0] pending_o,
    output logic            token_done_o,
    output logic            ovf_o
);

    localparam logic [pw_p-1:0] init_lp = pw_p'(init_p);

    logic [pw_p-1:0] pend_q;
    logic [pw_p-1:0] pend_d;

    if (lg_p == 0) begin : g_direct
        assign token_done_o = credit_i;
    end else begin : g_decim
        logic [lg_p-1:0] acc_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc_q <= '0;
            end else if (credit_i) begin
                acc_q <= acc_q + 1'b1;
            end
        end

        // the credit that wraps the count completes a token
        assign token_done_o = credit_i & (&acc_q);
    end

    always_comb begin
        pend_d = pend_q;
        ovf_o  = 1'b0;
        unique case ({token_done_o, take_i})
            2'b10: begin
                if (&pend_q) begin
                    ovf_o = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= init_lp;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/bsg_async_credit_returner.sv
// Credit returner: token clock/reset generator for the remote credit counter.
// Define BSG_ASYNC_CREDIT_RETURNER_ERR_EN to compile in sticky overflow detection.
module bsg_async_credit_returner
    import bsg_async_credit_returner_pkg::*;
#(
    parameter int lg_credit_to_token_decimation_p = 0,
    parameter int max_tokens_p       = 4,
    parameter int extra_margin_p     = 0,
    parameter int initial_tokens_p   = 0,
    parameter int hi_cycles_p        = 1,
    parameter int lo_cycles_p        = 1,
    parameter int reset_cycles_p     = 2,
    parameter int reset_gap_cycles_p = 4
) (
    input  logic w_clk_i,
    input  logic w_reset_i,
    bsg_async_credit_returner_if.master bus
);

    localparam int pw_lp = pw(max_tokens_p, extra_margin_p);
    localparam int seq_lp = reset_cycles_p + reset_gap_cycles_p;
    localparam int hl_lp = (hi_cycles_p > lo_cycles_p) ? hi_cycles_p : lo_cycles_p;
    localparam int cmax_lp = (seq_lp > hl_lp) ? seq_lp : hl_lp;
    localparam int cw_lp = $clog2(cmax_lp + 1);

    state_e state_q, state_d;
    logic [cw_lp-1:0] cnt_q, cnt_d;
    logic [pw_lp-1:0] pending;
    logic take;
    logic ovf;
    logic unused_token_done;
    logic clk_q, trst_q, ready_q;

    bsg_credit_token_accum #(
        .lg_p   (lg_credit_to_token_decimation_p),
        .pw_p   (pw_lp),
        .init_p (initial_tokens_p)
    ) accum (
        .clk          (w_clk_i),
        .reset        (w_reset_i),
        .credit_i     (bus.w_credit_i),
        .take_i       (take),
        .pending_o    (pending),
        .token_done_o (unused_token_done),
        .ovf_o        (ovf)
    );

    // cnt runs continuously through RST and GAP, measured from reset release
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        take    = 1'b0;
        unique case (state_q)
            RST: begin
                if (cnt_q == cw_lp'(reset_cycles_p)) begin
                    state_d = (reset_gap_cycles_p > 1) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (cnt_q == cw_lp'(seq_lp - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (pending != '0) begin
                    state_d = HI;
                    take    = 1'b1;
                end
            end
            HI: begin
                if (cnt_q == cw_lp'(hi_cycles_p - 1)) begin
                    state_d = LO;
                    cnt_d   = '0;
                end
            end
            LO: begin
                if (cnt_q == cw_lp'(lo_cycles_p - 1)) begin
                    cnt_d = '0;
                    if (pending != '0) begin
                        state_d = HI;
                        take    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = RST;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge w_clk_i or posedge w_reset_i) begin
        if (w_reset_i) begin
            state_q <= RST;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            trst_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clk_q   <= (state_d == HI);
            trst_q  <= (state_d == RST);
            ready_q <= (state_d == IDLE) || (state_d == HI) || (state_d == LO);
        end
    end

    assign bus.token_clk_o        = clk_q;
    assign bus.token_reset_o      = trst_q;
    assign bus.w_ready_o          = ready_q;
    assign bus.w_tokens_pending_o = pending;

`ifdef BSG_ASYNC_CREDIT_RETURNER_ERR_EN
    logic err_q;

    always_ff @(posedge w_clk_i or posedge w_reset_i) begin
        if (w_reset_i) begin
            err_q <= 1'b0;
        end else if (ovf) begin
            err_q <= 1'b1;
        end
    end

    assign bus.w_error_o = err_q;
`else
    logic unused_ovf;
    assign unused_ovf    = ovf;
    assign bus.w_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_async_credit_returner.sv
// Randomized bench for the credit returner against a timeline-based model.
`timescale 1ns/1ps
module tb_bsg_async_credit_returner;
    import bsg_async_credit_returner_pkg::*;

`ifdef BSG_ASYNC_CREDIT_RETURNER_ERR_EN
    localparam bit err_en = 1'b1;
`else
    localparam bit err_en = 1'b0;
`endif

    localparam int PWA = pw(4, 0);
    localparam int PWB = pw(1, 0);

    typedef struct packed {
        int lg; int pmax; int init; int hi; int lo; int r; int g;
    } cfg_t;

    typedef struct packed {
        int cyc; int pend; int credits; bit err; int last_start; int next_start;
    } model_t;

    localparam cfg_t CA = '{lg: 2, pmax: (1 << PWA) - 1, init: 2, hi: 2, lo: 3, r: 2, g: 4};
    localparam cfg_t CB = '{lg: 0, pmax: (1 << PWB) - 1, init: 0, hi: 1, lo: 1, r: 2, g: 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bsg_async_credit_returner_if #(.pw_p(PWA)) ia ();
    bsg_async_credit_returner_if #(.pw_p(PWB)) ib ();

    bsg_async_credit_returner #(
        .lg_credit_to_token_decimation_p(2), .max_tokens_p(4), .extra_margin_p(0),
        .initial_tokens_p(2), .hi_cycles_p(2), .lo_cycles_p(3),
        .reset_cycles_p(2), .reset_gap_cycles_p(4)
    ) dut_a (.w_clk_i(clk), .w_reset_i(rst), .bus(ia));

    bsg_async_credit_returner #(
        .lg_credit_to_token_decimation_p(0), .max_tokens_p(1), .extra_margin_p(0),
        .initial_tokens_p(0), .hi_cycles_p(1), .lo_cycles_p(1),
        .reset_cycles_p(2), .reset_gap_cycles_p(4)
    ) dut_b (.w_clk_i(clk), .w_reset_i(rst), .bus(ib));

    int passed = 0;
    int total = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic model_t minit(cfg_t c);
        model_t m;
        m.cyc = 0;
        m.pend = c.init;
        m.credits = 0;
        m.err = 1'b0;
        m.last_start = -1000;
        m.next_start = 0;
        return m;
    endfunction

    // one posedge: tokens start once ready, when owed and spacing allows
    function automatic model_t mstep(model_t m, cfg_t c, bit credit);
        int t;
        bit done, take;
        t = m.cyc + 1;
        done = 1'b0;
        if (credit) begin
            m.credits++;
            done = (m.credits % (1 << c.lg)) == 0;
        end
        take = (t > c.r + c.g) && (m.pend > 0) && (t >= m.next_start);
        if (take) begin
            m.last_start = t;
            m.next_start = t + c.hi + c.lo;
        end
        m.pend = m.pend + int'(done) - int'(take);
        if (m.pend > c.pmax) begin
            m.pend = c.pmax;
            if (err_en) m.err = 1'b1;
        end
        m.cyc = t;
        return m;
    endfunction

    model_t ma, mb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= minit(CA);
            mb <= minit(CB);
        end else begin
            ma <= mstep(ma, CA, ia.w_credit_i);
            mb <= mstep(mb, CB, ib.w_credit_i);
        end
    end

    always @(negedge clk) begin
        chk("a_token_reset", int'(ia.token_reset_o), int'(ma.cyc <= CA.r));
        chk("a_ready", int'(ia.w_ready_o), int'(ma.cyc >= CA.r + CA.g));
        chk("a_token_clk", int'(ia.token_clk_o),
            int'(ma.cyc >= ma.last_start && ma.cyc < ma.last_start + CA.hi));
        chk("a_pending", int'(ia.w_tokens_pending_o), ma.pend);
        chk("a_error", int'(ia.w_error_o), int'(ma.err));
        chk("b_token_reset", int'(ib.token_reset_o), int'(mb.cyc <= CB.r));
        chk("b_ready", int'(ib.w_ready_o), int'(mb.cyc >= CB.r + CB.g));
        chk("b_token_clk", int'(ib.token_clk_o),
            int'(mb.cyc >= mb.last_start && mb.cyc < mb.last_start + CB.hi));
        chk("b_pending", int'(ib.w_tokens_pending_o), mb.pend);
        chk("b_error", int'(ib.w_error_o), int'(mb.err));
    end

    int exp_trst [9];
    int exp_rdy [9];
    int exp_aclk [9];
    int exp_apend [9];

    task automatic reset_seq();
        ia.w_credit_i = 1'b0;
        ib.w_credit_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            chk("lit_token_reset", int'(ia.token_reset_o), exp_trst[k]);
            chk("lit_ready", int'(ia.w_ready_o), exp_rdy[k]);
            chk("lit_a_token_clk", int'(ia.token_clk_o), exp_aclk[k]);
            chk("lit_a_pending", int'(ia.w_tokens_pending_o), exp_apend[k]);
            chk("lit_b_token_clk", int'(ib.token_clk_o), 0);
        end
    endtask

    task automatic mid_reset();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        ia.w_credit_i = 1'b1;
        ib.w_credit_i = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = ia.token_clk_o;
        end
        chk("mid_wait_token", int'(seen), 1);
        #1 rst = 1'b1;
        ia.w_credit_i = 1'b0;
        #1;
        chk("mid_token_clk", int'(ia.token_clk_o), 0);
        chk("mid_token_reset", int'(ia.token_reset_o), 1);
        chk("mid_pending", int'(ia.w_tokens_pending_o), 2);
        @(negedge clk);
        reset_seq();
    endtask

    initial begin
        exp_trst  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        exp_rdy   = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        exp_aclk  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        exp_apend = '{2, 2, 2, 2, 2, 2, 1, 1, 1};
        ia.w_credit_i = 1'b0;
        ib.w_credit_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_seq();

        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ia.w_credit_i = 1'b1;
            ib.w_credit_i = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("dec_pending_1", int'(ia.w_tokens_pending_o), 1);
        chk("dec_clk_low", int'(ia.token_clk_o), 0);
        chk("ovf_pending_sat", int'(ib.w_tokens_pending_o), 1);
        chk("ovf_error", int'(ib.w_error_o), int'(err_en));
        @(negedge clk);
        ia.w_credit_i = 1'b0;
        ib.w_credit_i = 1'b0;
        @(posedge clk);
        #1;
        chk("dec_clk_high", int'(ia.token_clk_o), 1);
        chk("dec_pending_0", int'(ia.w_tokens_pending_o), 0);

        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                ia.w_credit_i = ($urandom_range(0, 1) == 1);
                ib.w_credit_i = ($urandom_range(0, 9) < 7);
            end
            mid_reset();
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bsg_async_credit_returner.md
# bsg_async_credit_returner

Consumer-side companion of the async credit counter: runs in the buffer-owner clock domain, counts credits freed by the local consumer, decimates them into tokens, and drives the token clock and token reset wires that feed the remote credit counter's increment domain. It also generates the remote reset handshake: reset pulse with the token clock held low, then a quiet gap. It guarantees that every emitted token is a clean 0->1->0 edge with programmable high and low widths.

## Interface
- lg_credit_to_token_decimation_p, 0: log2 of credits per token.
- max_tokens_p, 4: nominal buffer capacity in tokens.
- extra_margin_p, 0: extra bits of pending-token headroom.
- initial_tokens_p, 0: margin tokens owed at reset; must be ≤ 2^pw-1.
- hi_cycles_p, 1: cycles token_clk_o is held high per token; ≥1.
- lo_cycles_p, 1: minimum cycles token_clk_o is held low between tokens; ≥1.
- reset_cycles_p, 2: cycles token_reset_o is held high after local reset release; ≥1.
- reset_gap_cycles_p, 4: quiet cycles after token_reset_o falls, before the first token; ≥1.
- Derived: pw = extra_margin_p + $clog2(max_tokens_p+1), the pending counter width.

Ports:
- w_clk_i  in  1  local clock.
- w_reset_i  in  1  reset, asynchronous, active-high; clock w_clk_i.
- w_credit_i  in  1  one credit freed this cycle.
- w_ready_o  out  1  remote reset sequence complete; tokens may flow.
- w_tokens_pending_o  out  pw  tokens owed but not yet emitted.
- w_error_o  out  1  sticky pending-counter overflow.
- token_clk_o  out  1  token clock to the remote side; one rising edge per token.
- token_reset_o  out  1  reset to the remote token domain.

## Operation
- All outputs are registered.
- While w_reset_i is asserted: state RST, token_reset_o=1, token_clk_o=0, w_ready_o=0, w_error_o=0, credit accumulator=0, pending=initial_tokens_p.
- FSM states and transitions (cnt is a shared cycle counter):
  - RST -> GAP after reset_cycles_p posedges following deassertion; token_reset_o drops to 0.
  - GAP -> IDLE after reset_gap_cycles_p cycles; w_ready_o rises to 1 and stays 1 until the next reset.
  - IDLE -> HI when pending>0.
  - HI -> LO after hi_cycles_p cycles.
  - LO -> HI after lo_cycles_p cycles if pending>0; otherwise LO -> IDLE.
- token_clk_o is 1 only in HI. It never toggles in RST or GAP.
- Accumulator:
  - The lg-bit credit count increments on w_credit_i in every non-reset state, including RST and GAP.
  - When the count wraps (or on every credit when lg=0), a token completes and pending increments.
- Pending decrements on every entry into HI.
- Simultaneous token completion and HI entry: pending is unchanged.
- Overflow: if a token completes while pending is all-ones and no HI entry occurs that cycle, pending saturates and w_error_o is set.
- Asserting w_reset_i mid-token forces token_clk_o low immediately (asynchronous). Partial credits and pending tokens are discarded; pending reloads to initial_tokens_p.

## Timing
- Release w_reset_i before posedge 1. token_reset_o=1 through posedge reset_cycles_p, then 0.
- w_ready_o=1 after posedge reset_cycles_p+reset_gap_cycles_p.
- Token latency: a credit completing a token at posedge n (in IDLE, pending previously 0) gives token_clk_o=1 after posedge n+1.
- Throughput: at most one token per hi_cycles_p+lo_cycles_p cycles.
- w_tokens_pending_o reflects a completion or decrement one cycle after the causing edge.

## Configuration
- BSG_ASYNC_CREDIT_RETURNER_ERR_EN defined: overflow detection is compiled in and w_error_o is a sticky flag, cleared only by reset.
- Not defined: detection logic is removed, w_error_o is tied 0, and pending still saturates silently.

## Structure
- Package bsg_async_credit_returner_pkg holds:
  - the state enum {RST, GAP, IDLE, HI, LO};
  - the pending-width function pw(max_tokens, margin).
- Sub-module bsg_credit_token_accum holds the accumulator and the saturating pending counter. Its interface is credit_i, take_i, pending_o, token_done_o, ovf_o.
- The FSM and the output registers live in the top module.

## Test plan
- Reset sequence, defaults: token_reset_o=1 for posedges 1–2, 0 from posedge 3. w_ready_o=1 after posedge 6. token_clk_o=0 throughout.
- Decimation, lg=2: 4 w_credit_i pulses in IDLE give exactly one token_clk_o high cycle, the cycle after the 4th pulse. Pending goes 0->1->0.
- Backlog, hi=2, lo=3, 3 tokens queued: 3 highs of 2 cycles, separated by 3-cycle lows. Pending counts down 3,2,1,0.
- Margin, initial_tokens_p=2: 2 tokens are emitted right after w_ready_o rises, with no credits applied.
- Overflow, max_tokens_p=1 (pw=1), credits faster than tokens drain: pending saturates at 1. w_error_o is 1 with the macro and 0 without it.
- Mid-token reset: w_reset_i asserted during HI gives token_clk_o=0 and token_reset_o=1 immediately, then a full reset sequence restarts.
